// File: rtl/uart_cmd_scheduler.sv
// Parses 4-byte UART command frames (A5 CMD ARG CHK) and schedules single-shot or
// periodic measurement-start pulses, never starting while the core is busy.
module uart_cmd_scheduler #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_BITS = 20,
    parameter int TICK_CLKS    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       meas_busy,
    output logic       meas_start,
    output logic       mode_cont,
    output logic [7:0] period,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);
    localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW      = $clog2(TO_CLKS + 1);
    localparam int TW      = $clog2(TICK_CLKS + 1);

    typedef enum logic [2:0] {IDLE, GOT_HDR, GOT_CMD, GOT_ARG, EXEC} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, arg_q;
    logic [GW-1:0]   gap_q;
    logic [TW-1:0]   tick_q;
    logic [7:0]      pcnt_q;
    logic            pending_q;

    logic            in_frame, timeout, wrap, expire, issue;
    logic            dec_ok, dec_err, do_single, do_cont, do_stop;
    logic [1:0]      dec_code;

    assign in_frame = (state_q == GOT_HDR) || (state_q == GOT_CMD) || (state_q == GOT_ARG);
    assign timeout  = in_frame && !rx_done && (gap_q == GW'(TO_CLKS - 1));
    assign wrap     = mode_cont && (tick_q == TW'(TICK_CLKS - 1));
    assign expire   = wrap && ((pcnt_q + 8'd1) == period);
    assign issue    = pending_q && !meas_busy;

    // The frame is judged on the CHK byte itself so that the status pulse and the
    // configuration change are visible in the cycle right after the last rx_done.
    always_comb begin
        state_d   = state_q;
        dec_ok    = 1'b0;
        dec_err   = 1'b0;
        dec_code  = 2'd0;
        do_single = 1'b0;
        do_cont   = 1'b0;
        do_stop   = 1'b0;
        case (state_q)
            IDLE:    if (rx_done && rx_data == 8'hA5) state_d = GOT_HDR;
            GOT_HDR: if (rx_done) state_d = GOT_CMD; else if (timeout) state_d = IDLE;
            GOT_CMD: if (rx_done) state_d = GOT_ARG; else if (timeout) state_d = IDLE;
            GOT_ARG: begin
                if (rx_done) begin
                    state_d = EXEC;
                    if ((8'hA5 ^ cmd_q ^ arg_q) != rx_data) begin
                        dec_err  = 1'b1;
                        dec_code = 2'd1;
                    end else begin
                        case (cmd_q)
                            8'h01: begin dec_ok = 1'b1; do_single = 1'b1; end
                            8'h02: begin
                                if (arg_q == 8'd0) begin
                                    dec_err  = 1'b1;
                                    dec_code = 2'd2;
                                end else begin
                                    dec_ok  = 1'b1;
                                    do_cont = 1'b1;
                                end
                            end
                            8'h03: begin dec_ok = 1'b1; do_stop = 1'b1; end
                            default: begin dec_err = 1'b1; dec_code = 2'd2; end
                        endcase
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= 8'd0;
            arg_q      <= 8'd0;
            gap_q      <= '0;
            tick_q     <= '0;
            pcnt_q     <= 8'd0;
            pending_q  <= 1'b0;
            meas_start <= 1'b0;
            mode_cont  <= 1'b0;
            period     <= 8'd0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == GOT_HDR && rx_done) cmd_q <= rx_data;
            if (state_q == GOT_CMD && rx_done) arg_q <= rx_data;

            if (rx_done || !in_frame) gap_q <= '0;
            else                      gap_q <= gap_q + 1'b1;

            frame_ok  <= dec_ok;
            frame_err <= dec_err || timeout;
            if (dec_ok)       err_code <= 2'd0;
            else if (dec_err) err_code <= dec_code;
            else if (timeout) err_code <= 2'd3;

            if (!mode_cont || do_cont || do_stop) begin
                tick_q <= '0;
                pcnt_q <= 8'd0;
            end else if (wrap) begin
                tick_q <= '0;
                pcnt_q <= expire ? 8'd0 : pcnt_q + 8'd1;
            end else begin
                tick_q <= tick_q + 1'b1;
            end

            if (do_cont) begin
                mode_cont <= 1'b1;
                period    <= arg_q;
            end else if (do_stop) begin
                mode_cont <= 1'b0;
            end

            // New requests merge into a single pending flag; a stop overrides all.
            meas_start <= issue;
            if (do_stop)                             pending_q <= 1'b0;
            else if (expire || do_single || do_cont) pending_q <= 1'b1;
            else if (issue)                          pending_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Bench for uart_cmd_scheduler: table of frames, hand-written timing sequences and
// random frames judged by a frame-level model of the command rules.
module tb_uart_cmd_scheduler;
    localparam int CPB = 10, TOB = 20, TK = 10;

    logic       clk = 1'b0, rst, rx_done, meas_busy;
    logic [7:0] rx_data;
    logic       meas_start, mode_cont, frame_ok, frame_err;
    logic [7:0] period;
    logic [1:0] err_code;

    uart_cmd_scheduler #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB), .TICK_CLKS(TK)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .meas_busy(meas_busy),
        .meas_start(meas_start), .mode_cont(mode_cont), .period(period),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int st_q[$], ok_q[$], er_q[$];
    always @(negedge clk) begin
        if (meas_start) st_q.push_back(cyc);
        if (frame_ok)   ok_q.push_back(cyc);
        if (frame_err)  er_q.push_back(cyc);
    end

    int nvec = 0, nmis = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind 0 = meas_start, 1 = frame_ok, 2 = frame_err; counts events in [lo,hi]
    function automatic int cnt(input int kind, input int lo, input int hi);
        int n = 0;
        case (kind)
            0: foreach (st_q[i]) if (st_q[i] >= lo && st_q[i] <= hi) n++;
            1: foreach (ok_q[i]) if (ok_q[i] >= lo && ok_q[i] <= hi) n++;
            default: foreach (er_q[i]) if (er_q[i] >= lo && er_q[i] <= hi) n++;
        endcase
        return n;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the edge index at which the byte was consumed.
    task automatic send_byte(input logic [7:0] b, output int e);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        e = cyc;
    endtask

    task automatic send_frame(input logic [31:0] f, output int e);
        for (int i = 0; i < 4; i++) begin
            send_byte(f[31-8*i -: 8], e);
            if (i < 3) clks(99);
        end
    endtask

    typedef struct {
        logic [31:0] frame;
        int exp_ok, exp_err, exp_code, exp_mode, exp_period, exp_start;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e, e2, l, s, r, bad, nexp;
        int m_mode, m_period, m_code;
        logic [7:0] cmd, arg, chkb, junk;
        bit corrupt, exp_ok, single_like;

        vt[0] = '{32'hA50100A4, 1, 0, 0, 0, 0, 1};
        vt[1] = '{32'hA5010000, 0, 1, 1, 0, 0, 0};
        vt[2] = '{32'hA50700A2, 0, 1, 2, 0, 0, 0};
        vt[3] = '{32'hA50200A7, 0, 1, 2, 0, 0, 0};
        vt[4] = '{32'hA50100A4, 1, 0, 0, 0, 0, 1};
        vt[5] = '{32'hA50300A6, 1, 0, 0, 0, 0, 0};

        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; meas_busy = 1'b0;
        clks(3);
        chk("reset_meas_start", meas_start, 0);
        chk("reset_mode_cont", mode_cont, 0);
        chk("reset_period", period, 0);
        chk("reset_frame_ok", frame_ok, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_err_code", err_code, 0);
        rst = 1'b0;
        clks(5);

        foreach (vt[i]) begin
            send_frame(vt[i].frame, e);
            clks(60);
            chk($sformatf("vec%0d_frame_ok", i), cnt(1, e, e), vt[i].exp_ok);
            chk($sformatf("vec%0d_frame_err", i), cnt(2, e, e), vt[i].exp_err);
            chk($sformatf("vec%0d_err_code", i), err_code, vt[i].exp_code);
            chk($sformatf("vec%0d_mode", i), mode_cont, vt[i].exp_mode);
            chk($sformatf("vec%0d_period", i), period, vt[i].exp_period);
            chk($sformatf("vec%0d_start_at_n2", i), cnt(0, e + 1, e + 1), vt[i].exp_start);
            chk($sformatf("vec%0d_start_total", i), cnt(0, e, e + 60), vt[i].exp_start);
        end

        // continuous mode cadence, then stop
        send_frame(32'hA5020AAD, e);
        chk("cont_mode", mode_cont, 1);
        chk("cont_period", period, 8'h0A);
        clks(350);
        send_frame(32'hA50300A6, e2);
        nexp = (e2 - (e + 1)) / 100 + 1;
        bad = 0;
        foreach (st_q[i]) if (st_q[i] >= e && st_q[i] <= e2 && ((st_q[i] - e - 1) % 100) != 0) bad++;
        chk("cont_first_start", cnt(0, e + 1, e + 1), 1);
        chk("cont_start_count", cnt(0, e, e2), nexp);
        chk("cont_misaligned_starts", bad, 0);
        chk("stop_mode", mode_cont, 0);
        clks(1000);
        chk("stop_no_starts", cnt(0, e2 + 1, e2 + 1000), 0);

        // busy hold: expiries during busy collapse into one start after it drops
        send_frame(32'hA5020AAD, e);
        clks(20);
        meas_busy = 1'b1;
        clks(350);
        meas_busy = 1'b0;
        clks(60);
        chk("busy_first_start", cnt(0, e + 1, e + 1), 1);
        chk("busy_hold_none", cnt(0, e + 2, e + 370), 0);
        chk("busy_release_start", cnt(0, e + 371, e + 371), 1);
        chk("busy_gap_none", cnt(0, e + 372, e + 400), 0);
        chk("busy_cadence_resume", cnt(0, e + 401, e + 401), 1);
        send_frame(32'hA50300A6, e);
        clks(60);

        // timeout then resync past a junk byte
        send_byte(8'hA5, e);
        clks(99);
        send_byte(8'h01, l);
        clks(250);
        chk("timeout_err_time", cnt(2, l + 200, l + 200), 1);
        chk("timeout_err_once", cnt(2, l, l + 250), 1);
        chk("timeout_err_code", err_code, 3);
        chk("timeout_no_start", cnt(0, l, l + 250), 0);
        s = cyc;
        send_byte(8'h55, e);
        clks(99);
        send_frame(32'hA50100A4, e);
        clks(60);
        chk("resync_no_err", cnt(2, s, e + 60), 0);
        chk("resync_frame_ok", cnt(1, e, e), 1);
        chk("resync_err_code", err_code, 0);
        chk("resync_start", cnt(0, e + 1, e + 1), 1);

        // random frames against the command rules
        m_mode = 0; m_period = 8'h0A; m_code = 0;
        for (int it = 0; it < 25; it++) begin
            s = cyc;
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, e);
                clks(99);
            end
            case ($urandom_range(0, 4))
                0, 4: cmd = 8'h01;
                1:    cmd = 8'h02;
                2:    cmd = 8'h03;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            arg = (cmd == 8'h02) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
            corrupt = ($urandom_range(0, 5) == 0);
            chkb = 8'hA5 ^ cmd ^ arg;
            if (corrupt) chkb = chkb ^ 8'($urandom_range(1, 255));
            send_frame({8'hA5, cmd, arg, chkb}, e);
            clks(50);

            exp_ok = 1'b0;
            single_like = 1'b0;
            if (corrupt) m_code = 1;
            else if (cmd == 8'h01) begin exp_ok = 1'b1; single_like = 1'b1; end
            else if (cmd == 8'h02 && arg != 0) begin
                exp_ok = 1'b1; single_like = 1'b1; m_mode = 1; m_period = int'(arg);
            end
            else if (cmd == 8'h03) begin exp_ok = 1'b1; m_mode = 0; end
            else m_code = 2;
            if (exp_ok) m_code = 0;

            chk($sformatf("rnd%0d_ok", it), cnt(1, e, e), int'(exp_ok));
            chk($sformatf("rnd%0d_err", it), cnt(2, s, e + 50), int'(!exp_ok));
            chk($sformatf("rnd%0d_code", it), err_code, m_code);
            chk($sformatf("rnd%0d_mode", it), mode_cont, m_mode);
            chk($sformatf("rnd%0d_period", it), period, m_period);
            if (single_like)
                chk($sformatf("rnd%0d_start", it), cnt(0, e + 1, e + 1), 1);
            else if (m_mode == 0)
                chk($sformatf("rnd%0d_no_start", it), cnt(0, e + 1, e + 50), 0);
        end

        // reset in the middle of a frame while continuous mode is running
        send_frame(32'hA50205A2, e);
        clks(30);
        chk("pre_reset_mode", mode_cont, 1);
        send_byte(8'hA5, e);
        clks(99);
        send_byte(8'h02, e);
        clks(50);
        rst = 1'b1;
        clks(1);
        r = cyc;
        rst = 1'b0;
        chk("rst_mode", mode_cont, 0);
        chk("rst_period", period, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_meas_start", meas_start, 0);
        clks(49);
        send_byte(8'h0A, e);
        clks(99);
        send_byte(8'hAD, e);
        clks(100);
        chk("rst_no_frame_ok", cnt(1, r, e + 100), 0);
        chk("rst_no_frame_err", cnt(2, r, e + 100), 0);
        chk("rst_no_starts", cnt(0, r, e + 100), 0);
        chk("rst_mode_after", mode_cont, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/uart_cmd_scheduler.md
Name: uart_cmd_scheduler

Overview:
- Sits between the UART receiver (byte-done pulse plus 8-bit data) and the range-measurement core.
- Parses 4-byte command frames from the host and configures single-shot or continuous measurement mode.
- Schedules measurement-start pulses to the core and never issues a start while the core is busy.
- Reports frame status as pulses plus a sticky error code.

Parameters:
- CLKS_PER_BIT, 5208, clocks per UART bit at 50 MHz / 9600 baud; used only for the timeout.
- TIMEOUT_BITS, 20, maximum gap between bytes of one frame, in bit periods.
- TICK_CLKS, 50000, clocks per scheduler tick (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_done  in  1  one-clock pulse: rx_data holds a valid received byte
- rx_data  in  8  received byte
- meas_busy  in  1  high while the measurement core is running
- meas_start  out  1  one-clock pulse requesting a measurement
- mode_cont  out  1  1 = continuous mode active
- period  out  8  current continuous period in ticks
- frame_ok  out  1  one-clock pulse: valid frame executed
- frame_err  out  1  one-clock pulse: frame rejected
- err_code  out  2  last error (0 none, 1 checksum, 2 bad cmd/arg, 3 timeout); sticky until the next frame_ok

Behaviour:
- Reset: on rst=1 at a clk edge, all outputs go to 0, the FSM goes to IDLE, and the pending flag and all counters clear. rst overrides everything, including mid-frame and mid-period.
- Frame format: 0xA5, CMD, ARG, CHK, where CHK = 0xA5 ^ CMD ^ ARG.
- FSM states: IDLE, GOT_HDR, GOT_CMD, GOT_ARG, EXEC.
  - IDLE: rx_done with 0xA5 -> GOT_HDR. Any other byte is discarded silently (no error pulse).
  - GOT_HDR: rx_done latches CMD -> GOT_CMD.
  - GOT_CMD: rx_done latches ARG -> GOT_ARG.
  - GOT_ARG: rx_done latches CHK -> EXEC.
  - EXEC: lasts exactly one clock, then -> IDLE.
- Frame-status latency: rx_done of CHK in cycle N -> frame_ok or frame_err asserted in cycle N+1.
- EXEC checks, in priority order:
  - Checksum mismatch -> frame_err, err_code=1.
  - CMD 0x01: single shot. Set the pending flag; mode is unchanged.
  - CMD 0x02: start continuous. ARG 0 -> frame_err, err_code=2. Otherwise period<=ARG, mode_cont<=1, tick and period counters clear, pending set (immediate first shot).
  - CMD 0x03: stop. mode_cont<=0, pending cleared, period unchanged.
  - Any other CMD -> frame_err, err_code=2.
  - On a rejected frame, configuration is unchanged.
  - frame_ok also resets err_code to 0.
- Timeout:
  - A gap counter clears on each rx_done and counts in GOT_HDR, GOT_CMD and GOT_ARG.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT: frame_err, err_code=3, FSM -> IDLE, partial frame dropped.
  - IDLE never times out.
- Ignored input: rx_done arriving in EXEC is ignored, because the host must not send faster than 1 byte per bit time.
- Scheduler (continuous mode):
  - Tick counter counts 0..TICK_CLKS-1 and wraps.
  - On each wrap the period counter increments. When it reaches period, it clears and sets pending.
  - Counters are frozen and cleared when mode_cont=0.
- Start issue:
  - When pending=1 and meas_busy=0, meas_start pulses for one clock and pending clears in the same cycle.
  - meas_start therefore rises at earliest cycle N+2 after the CHK rx_done.
  - While meas_busy=1, pending holds. At most one request is queued; extra requests merge into it, with no overrun error.
- Simultaneous events:
  - A stop (EXEC) in the same cycle as a period expiry: stop wins and pending ends at 0.
  - A single-shot in continuous mode merges with any pending request.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Bench overrides: CLKS_PER_BIT=10, TICK_CLKS=10, TIMEOUT_BITS=20. Bytes are driven as rx_done pulses spaced 100 clocks apart.
- Single shot: bytes A5 01 00 A4 with meas_busy=0 -> frame_ok 1 clk after the last rx_done; one meas_start pulse 1 clk later; mode_cont=0; err_code=0.
- Continuous mode: A5 02 0A AD -> mode_cont=1, period=0x0A, immediate meas_start, then meas_start every 100 clocks. Next, A5 03 00 A6 -> mode_cont=0 and no further meas_start for 1000 clocks.
- Busy hold: in continuous mode with period 0x0A, hold meas_busy=1 for 350 clocks -> exactly one meas_start, 1 clock after meas_busy falls; the cadence then resumes.
- Errors:
  - A5 01 00 00 -> frame_err, err_code=1, no meas_start.
  - A5 07 00 A2 -> frame_err, err_code=2.
  - A5 02 00 A7 -> frame_err, err_code=2, mode unchanged.
  - A following valid frame -> err_code=0.
- Timeout and resync:
  - Send A5 01, then idle 250 clocks -> frame_err with err_code=3 at 200 clocks after the last byte.
  - Then send 55 A5 01 00 A4 -> the 55 is discarded silently; frame_ok follows.
- Reset mid-frame: send A5 02, assert rst for 1 clk, then send 0A AD -> all outputs 0 and no frame_ok (0A and AD are discarded in IDLE).
